countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/microondas_pkg.sv | 18 +
 rtl/countdown_timer_if.sv | 27 ++
 rtl/bcd_digit_down.sv | 23 ++
 rtl/countdown_timer.sv | 90 +++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// rtl/microondas_pkg.sv - shared state encodings and BCD limits for the countdown timer
package microondas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] MAX_SEC_TENS = 4'd5;
  localparam logic [3:0] MAX_DIGIT    = 4'd9;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - keypad, control and BCD display bundle of the countdown timer
interface countdown_timer_if;
  import microondas_pkg::*;

  logic       tick_1hz;
  logic       digit_valid;
  logic [3:0] digit;
  logic       limpan;
  logic       m_on;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       tdone;
  state_t     state;

  modport master (
    output tick_1hz, digit_valid, digit, limpan, m_on,
    input  min_tens, min_ones, sec_tens, sec_ones, tdone, state
  );

  modport slave (
    input  tick_1hz, digit_valid, digit, limpan, m_on,
    output min_tens, min_ones, sec_tens, sec_ones, tdone, state
  );

endinterface

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one BCD digit of a down-counter with borrow chain
module bcd_digit_down (
  input  logic [3:0] digit_i,
  input  logic       borrow_in_i,
  input  logic [3:0] wrap_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_in_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = wrap_i;
        borrow_o = 1'b1;
      end else begin
        digit_o  = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - microwave MM:SS countdown with keypad entry, pause and expiry flag
module countdown_timer
  import microondas_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  countdown_timer_if.slave   bus
);

  logic [15:0] count_q;
  logic        tdone_q;
  state_t      state_q;

  logic [15:0] count_dec;
  logic [3:0]  borrow;
  logic        underflow;
  logic [15:0] count_shift;

  // Chain ripples from seconds-ones upward; the tick itself is the first borrow.
  bcd_digit_down u_sec_ones (
    .digit_i(count_q[3:0]), .borrow_in_i(1'b1), .wrap_i(MAX_DIGIT),
    .digit_o(count_dec[3:0]), .borrow_o(borrow[0])
  );
  bcd_digit_down u_sec_tens (
    .digit_i(count_q[7:4]), .borrow_in_i(borrow[0]), .wrap_i(MAX_SEC_TENS),
    .digit_o(count_dec[7:4]), .borrow_o(borrow[1])
  );
  bcd_digit_down u_min_ones (
    .digit_i(count_q[11:8]), .borrow_in_i(borrow[1]), .wrap_i(MAX_DIGIT),
    .digit_o(count_dec[11:8]), .borrow_o(borrow[2])
  );
  bcd_digit_down u_min_tens (
    .digit_i(count_q[15:12]), .borrow_in_i(borrow[2]), .wrap_i(MAX_DIGIT),
    .digit_o(count_dec[15:12]), .borrow_o(borrow[3])
  );

  // A borrow out of the top digit means the count was already zero; never wrap.
  assign underflow   = borrow[3];
  assign count_shift = {count_q[11:0], bus.digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
      tdone_q <= 1'b0;
      state_q <= ST_IDLE;
    end else if (!bus.limpan) begin
      count_q <= 16'h0000;
      tdone_q <= 1'b0;
      state_q <= ST_IDLE;
    end else if (bus.digit_valid && digit_ok(bus.digit) && state_q != ST_RUN) begin
      count_q <= count_shift;
      tdone_q <= 1'b0;
      state_q <= (count_shift != 16'h0000) ? ST_LOADED : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.m_on) begin
            tdone_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_LOADED: begin
          if (bus.m_on) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!bus.m_on) begin
            state_q <= ST_LOADED;
          end else if (bus.tick_1hz && !underflow) begin
            count_q <= count_dec;
            if (count_dec == 16'h0000) begin
              tdone_q <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        default: begin
          tdone_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.min_tens = count_q[15:12];
  assign bus.min_ones = count_q[11:8];
  assign bus.sec_tens = count_q[7:4];
  assign bus.sec_ones = count_q[3:0];
  assign bus.tdone    = tdone_q;
  assign bus.state    = state_q;

endmodule
